boolean_function_checker: RTL and testbench

Self-checking response analyzer for small combinational blocks under test. On `start` it sweeps every input vector of an `N_IN`-input Boolean function through the DUT, waits a fixed settle time and samples the DUT output. It compares each sample against a parameterised expected truth table and reports an error count, the first failing vector and pass/fail. It sits opposite the exhaustive stimulus generators used on the combinational labs: it drives the DUT's inputs and judges the DUT's output, so a function can be checked on the board without a simulator.

---
 rtl/boolean_function_checker.sv | 150 +++++++++++++++
 tb/tb_boolean_function_checker.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/boolean_function_checker.sv
`default_nettype none
// ============================================================================
// Module   : boolean_function_checker
// Brief    : Sweeps every input vector of an N_IN-input function, samples the
//            DUT output after SETTLE cycles and scores it against TRUTH.
//            Define CHECKER_HALT_ON_FAIL_EN to stop at the first mismatch.
// Revision : 1.0 - initial release
// ============================================================================
module boolean_function_checker #(
    parameter int                     N_IN   = 3,
    parameter logic [(1<<N_IN)-1:0]   TRUTH  = 8'hE8,
    parameter int                     SETTLE = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    output logic [N_IN-1:0] vec_out,
    input  logic            dut_in,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_cnt,
    output logic [N_IN-1:0] first_fail,
    output logic            first_fail_vld
);

    localparam int CNT_W = (SETTLE > 2) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] SETTLE_RELOAD = CNT_W'(SETTLE - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [N_IN:0]   err_cnt_q, err_cnt_d;
    logic [N_IN-1:0] first_fail_q, first_fail_d;
    logic            first_fail_vld_q, first_fail_vld_d;

    logic            mismatch;
    logic            last_vec;
    logic            halt;

    assign mismatch = (dut_in != TRUTH[vec_q]);
    assign last_vec = &vec_q;

`ifdef CHECKER_HALT_ON_FAIL_EN
    assign halt = mismatch;
`else
    assign halt = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q          <= ST_IDLE;
            vec_q            <= '0;
            cnt_q            <= '0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            err_cnt_q        <= '0;
            first_fail_q     <= '0;
            first_fail_vld_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            vec_q            <= vec_d;
            cnt_q            <= cnt_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            err_cnt_q        <= err_cnt_d;
            first_fail_q     <= first_fail_d;
            first_fail_vld_q <= first_fail_vld_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        vec_d            = vec_q;
        cnt_d            = cnt_q;
        busy_d           = busy_q;
        done_d           = done_q;
        err_cnt_d        = err_cnt_q;
        first_fail_d     = first_fail_q;
        first_fail_vld_d = first_fail_vld_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // DONE holds its results until a new sweep is accepted
                if (start) begin
                    err_cnt_d        = '0;
                    first_fail_d     = '0;
                    first_fail_vld_d = 1'b0;
                    done_d           = 1'b0;
                    vec_d            = '0;
                    cnt_d            = SETTLE_RELOAD;
                    busy_d           = 1'b1;
                    state_d          = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_SAMPLE: begin
                // Scoring and the end-of-sweep transition share this edge
                if (mismatch) begin
                    err_cnt_d = err_cnt_q + (N_IN+1)'(1);
                    if (!first_fail_vld_q) begin
                        first_fail_d     = vec_q;
                        first_fail_vld_d = 1'b1;
                    end
                end
                if (last_vec || halt) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    vec_d   = '0;
                end else begin
                    vec_d   = vec_q + N_IN'(1);
                    cnt_d   = SETTLE_RELOAD;
                    state_d = ST_WAIT;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign vec_out        = vec_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err_cnt        = err_cnt_q;
    assign first_fail     = first_fail_q;
    assign first_fail_vld = first_fail_vld_q;
    assign pass           = done_q && (err_cnt_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_boolean_function_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_boolean_function_checker
// Brief    : Scoreboard bench for boolean_function_checker (default and
//            2-input XOR configurations) with a fault-injecting DUT model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_boolean_function_checker;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Configuration A: defaults (3 inputs, majority, SETTLE=2)
    logic       start_a = 1'b0;
    logic [2:0] vec_a;
    logic       d_a = 1'b0;
    logic       busy_a, done_a, pass_a, ffv_a;
    logic [3:0] err_a;
    logic [2:0] ff_a;
    logic [7:0] truth_a = 8'hE8;
    logic [7:0] flip_a  = 8'h00;

    // Configuration B: 2-input XOR, SETTLE=1
    logic       start_b = 1'b0;
    logic [1:0] vec_b;
    logic       d_b = 1'b0;
    logic       busy_b, done_b, pass_b, ffv_b;
    logic [2:0] err_b;
    logic [1:0] ff_b;
    logic [3:0] truth_b = 4'h6;
    logic [3:0] flip_b  = 4'h0;

    boolean_function_checker u_dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .vec_out(vec_a),
        .dut_in(d_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_cnt(err_a), .first_fail(ff_a), .first_fail_vld(ffv_a)
    );

    boolean_function_checker #(.N_IN(2), .TRUTH(4'h6), .SETTLE(1)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .vec_out(vec_b),
        .dut_in(d_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_cnt(err_b), .first_fail(ff_b), .first_fail_vld(ffv_b)
    );

    // Function under test: registered truth table with optional per-vector faults
    always @(posedge clk) begin
        d_a <= truth_a[vec_a] ^ flip_a[vec_a];
        d_b <= truth_b[vec_b] ^ flip_b[vec_b];
    end

    typedef struct {
        int k;
        int lat;
        int err;
        int ff;
        int ffv;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Expected result of one sweep over 2^n vectors with the given fault mask
    function automatic exp_t model(input int n, input int s, input int mask, input int k);
        exp_t e;
        int   first = -1;
        e.k   = k;
        e.err = 0;
        for (int i = 0; i < (1 << n); i++) begin
            if ((mask >> i) & 1) begin
                e.err++;
                if (first < 0) first = i;
            end
        end
        e.lat = (1 << n) * (s + 1);
`ifdef CHECKER_HALT_ON_FAIL_EN
        if (first >= 0) begin
            e.err = 1;
            e.lat = (first + 1) * (s + 1);
        end
`endif
        e.ff  = (first < 0) ? 0 : first;
        e.ffv = (first < 0) ? 0 : 1;
        return e;
    endfunction

    initial begin : mon_a
        logic prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (done_a && !prev) begin
                if (q_a.size() == 0) begin
                    check("a_unexpected_done", 1, 0);
                end else begin
                    e = q_a.pop_front();
                    check("a_latency", cyc - e.k, e.lat);
                    check("a_err_cnt", int'(err_a), e.err);
                    check("a_first_fail", int'(ff_a), e.ff);
                    check("a_first_fail_vld", int'(ffv_a), e.ffv);
                    check("a_pass", int'(pass_a), (e.err == 0) ? 1 : 0);
                    check("a_busy_in_done", int'(busy_a), 0);
                    check("a_vec_in_done", int'(vec_a), 0);
                end
            end
            prev = done_a;
        end
    end

    initial begin : mon_b
        logic prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (done_b && !prev) begin
                if (q_b.size() == 0) begin
                    check("b_unexpected_done", 1, 0);
                end else begin
                    e = q_b.pop_front();
                    check("b_latency", cyc - e.k, e.lat);
                    check("b_err_cnt", int'(err_b), e.err);
                    check("b_first_fail", int'(ff_b), e.ff);
                    check("b_first_fail_vld", int'(ffv_b), e.ffv);
                    check("b_pass", int'(pass_b), (e.err == 0) ? 1 : 0);
                    check("b_vec_in_done", int'(vec_b), 0);
                end
            end
            prev = done_b;
        end
    end

    task automatic pulse_a(input logic [7:0] mask, input bit expect_run);
        @(negedge clk);
        flip_a  = mask;
        start_a = 1'b1;
        if (expect_run) q_a.push_back(model(3, 2, int'(mask), cyc + 1));
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic pulse_b(input logic [3:0] mask);
        @(negedge clk);
        flip_b  = mask;
        start_b = 1'b1;
        q_b.push_back(model(2, 1, int'(mask), cyc + 1));
        @(negedge clk);
        start_b = 1'b0;
    endtask

    task automatic wait_done_a();
        int n = 0;
        while (!done_a && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!done_a) check("a_done_timeout", 0, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_done_b();
        int n = 0;
        while (!done_b && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!done_b) check("b_done_timeout", 0, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_vec"}, int'(vec_a), 0);
        check({tag, "_busy"}, int'(busy_a), 0);
        check({tag, "_done"}, int'(done_a), 0);
        check({tag, "_pass"}, int'(pass_a), 0);
        check({tag, "_err"}, int'(err_a), 0);
        check({tag, "_ff"}, int'(ff_a), 0);
        check({tag, "_ffv"}, int'(ffv_a), 0);
    endtask

    initial begin : stim
        int n;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_reset_a("rst_a");
        check("rst_b_busy", int'(busy_b), 0);
        check("rst_b_done", int'(done_b), 0);

        // Clean, single-fault, fully inverted, then random fault patterns
        pulse_a(8'h00, 1'b1); wait_done_a();
        pulse_a(8'h20, 1'b1); wait_done_a();
        pulse_a(8'hFF, 1'b1); wait_done_a();
        for (int i = 0; i < 5; i++) begin
            pulse_a(8'($urandom), 1'b1);
            wait_done_a();
        end

        // A start while busy is dropped; timing checked by the monitor
        pulse_a(8'h80, 1'b1);
        repeat (5) @(negedge clk);
        pulse_a(8'h80, 1'b0);
        wait_done_a();
        pulse_a(8'h00, 1'b1);
        check("a_restart_done_clr", int'(done_a), 0);
        check("a_restart_err_clr", int'(err_a), 0);
        check("a_restart_ffv_clr", int'(ffv_a), 0);
        check("a_restart_busy", int'(busy_a), 1);
        wait_done_a();

        // Reset while vector 3 is waiting to settle
        pulse_a(8'h00, 1'b0);
        n = 0;
        while (vec_a != 3'd3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("a_reached_vec3", int'(vec_a), 3);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check_reset_a("midrst_a");
        repeat (40) @(negedge clk);
        check("midrst_a_no_done", int'(done_a), 0);
        check("midrst_a_idle_vec", int'(vec_a), 0);

        // XOR configuration
        pulse_b(4'h0); wait_done_b();
        for (int i = 0; i < 3; i++) begin
            pulse_b(4'($urandom));
            wait_done_b();
        end

        check("a_queue_drained", q_a.size(), 0);
        check("b_queue_drained", q_b.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
